// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: source encoding,
// wait-counter width and the request payload layout.
package wb_pkg;

  localparam int WB_CNT_W = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LD   = 2'd1,
    MD   = 2'd2,
    ALU  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [4:0]  Rd;
    logic [31:0] Data;
  } wb_req_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer handshakes and register-file write port of the writeback arbiter.
// master: producers plus register file (bench side); slave: the arbiter.
interface writeback_arbiter_if;
  import wb_pkg::*;

  logic          Ld_Valid;
  logic          Ld_Ready;
  logic [4:0]    Ld_Rd;
  logic [31:0]   Ld_Data;

  logic          Md_Valid;
  logic          Md_Ready;
  logic [4:0]    Md_Rd;
  logic [31:0]   Md_Data;

  logic          Alu_Valid;
  logic          Alu_Ready;
  logic [4:0]    Alu_Rd;
  logic [31:0]   Alu_Data;

  logic          Reg_Write;
  logic [4:0]    Wr_Address;
  logic [31:0]   Wr_Data;
  wb_src_e       Grant_Src;

  modport master (
    output Ld_Valid, Ld_Rd, Ld_Data,
    output Md_Valid, Md_Rd, Md_Data,
    output Alu_Valid, Alu_Rd, Alu_Data,
    input  Ld_Ready, Md_Ready, Alu_Ready,
    input  Reg_Write, Wr_Address, Wr_Data, Grant_Src
  );

  modport slave (
    input  Ld_Valid, Ld_Rd, Ld_Data,
    input  Md_Valid, Md_Rd, Md_Data,
    input  Alu_Valid, Alu_Rd, Alu_Data,
    output Ld_Ready, Md_Ready, Alu_Ready,
    output Reg_Write, Wr_Address, Wr_Data, Grant_Src
  );

endinterface

// File: rtl/writeback_arbiter_starve_counter.sv
// Saturating wait counter for one lower-priority writeback source.
// Counts cycles the source waits while valid; Promoted once it reaches Limit.
module wb_starve_counter
  import wb_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Valid,
  input  logic                Grant,
  input  logic [WB_CNT_W-1:0] Limit,
  output logic                Promoted
);

  logic [WB_CNT_W-1:0] wait_cnt;

  // Count blocked cycles, hold at the limit, clear when the source is served.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wait_cnt <= '0;
    end else if (Grant) begin
      wait_cnt <= '0;
    end else if (Valid && (wait_cnt != Limit)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign Promoted = (wait_cnt == Limit);

endmodule

// File: rtl/writeback_arbiter.sv
// Single writer for the RV32IM register file. Picks one of load, mul/div and
// ALU results per cycle (base order Ld > Md > Alu) and registers the write.
// Build option: define WB_STARVE_GUARD_EN to add Md/Alu wait counters that
// promote a source above Ld after STARVE_LIMIT blocked cycles; without it the
// priority is strictly fixed.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  writeback_arbiter_if.slave  wb
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("writeback_arbiter: STARVE_LIMIT must be 1..15");
  end

  wb_src_e grant;
  wb_req_t sel_req;
  logic    md_boost;
  logic    alu_boost;

`ifdef WB_STARVE_GUARD_EN
  localparam logic [WB_CNT_W-1:0] LIMIT_C = WB_CNT_W'(STARVE_LIMIT);

  logic md_promoted;
  logic alu_promoted;

  wb_starve_counter u_md_starve (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Valid    (wb.Md_Valid),
    .Grant    (grant == MD),
    .Limit    (LIMIT_C),
    .Promoted (md_promoted)
  );

  wb_starve_counter u_alu_starve (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Valid    (wb.Alu_Valid),
    .Grant    (grant == ALU),
    .Limit    (LIMIT_C),
    .Promoted (alu_promoted)
  );

  // Gate with Valid so a promotion can never raise Ready on an idle source.
  assign md_boost  = md_promoted  && wb.Md_Valid;
  assign alu_boost = alu_promoted && wb.Alu_Valid;
`else
  assign md_boost  = 1'b0;
  assign alu_boost = 1'b0;
`endif

  // Grant select: promoted sources first (Md before Alu), then Ld > Md > Alu.
  always_comb begin
    grant = NONE;
    if (md_boost) begin
      grant = MD;
    end else if (alu_boost) begin
      grant = ALU;
    end else if (wb.Ld_Valid) begin
      grant = LD;
    end else if (wb.Md_Valid) begin
      grant = MD;
    end else if (wb.Alu_Valid) begin
      grant = ALU;
    end
  end

  assign wb.Ld_Ready  = (grant == LD);
  assign wb.Md_Ready  = (grant == MD);
  assign wb.Alu_Ready = (grant == ALU);

  // Payload mux for the granted source.
  always_comb begin
    sel_req = '0;
    case (grant)
      LD:      sel_req = '{Rd: wb.Ld_Rd,  Data: wb.Ld_Data};
      MD:      sel_req = '{Rd: wb.Md_Rd,  Data: wb.Md_Data};
      ALU:     sel_req = '{Rd: wb.Alu_Rd, Data: wb.Alu_Data};
      default: sel_req = '0;
    endcase
  end

  // Output stage: load on transfer (x0 is consumed without a write), else idle
  // with address/data held.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wb.Reg_Write  <= 1'b0;
      wb.Wr_Address <= '0;
      wb.Wr_Data    <= '0;
      wb.Grant_Src  <= NONE;
    end else if (grant != NONE) begin
      wb.Reg_Write  <= (sel_req.Rd != 5'd0);
      wb.Wr_Address <= sel_req.Rd;
      wb.Wr_Data    <= sel_req.Data;
      wb.Grant_Src  <= grant;
    end else begin
      wb.Reg_Write  <= 1'b0;
      wb.Grant_Src  <= NONE;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter. Expected register-file writes are
// queued as each cycle's stimulus is applied and compared one edge later.
module tb_writeback_arbiter;
  import wb_pkg::*;

  logic Clk;
  logic Rst_n;

  writeback_arbiter_if wb_if ();

  writeback_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .wb    (wb_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  src;
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check this cycle's Ready pattern and queue the write it must produce.
  task automatic expect_cycle(input logic [1:0] src);
    exp_t        e;
    logic [4:0]  rd;
    logic [31:0] d;
    #1;
    chk("ld_ready",  32'(wb_if.Ld_Ready),  32'(src == 2'd1));
    chk("md_ready",  32'(wb_if.Md_Ready),  32'(src == 2'd2));
    chk("alu_ready", 32'(wb_if.Alu_Ready), 32'(src == 2'd3));
    rd = '0;
    d  = '0;
    case (src)
      2'd1: begin rd = wb_if.Ld_Rd;  d = wb_if.Ld_Data;  end
      2'd2: begin rd = wb_if.Md_Rd;  d = wb_if.Md_Data;  end
      2'd3: begin rd = wb_if.Alu_Rd; d = wb_if.Alu_Data; end
      default: ;
    endcase
    if (src != 2'd0) begin
      exp_addr = rd;
      exp_data = d;
    end
    e.src  = src;
    e.rw   = (src != 2'd0) && (rd != 5'd0);
    e.addr = exp_addr;
    e.data = exp_data;
    sb.push_back(e);
  endtask

  // Output monitor: compare the registered write port after each edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant_src",  32'(wb_if.Grant_Src),  32'(e.src));
      chk("reg_write",  32'(wb_if.Reg_Write),  32'(e.rw));
      chk("wr_address", 32'(wb_if.Wr_Address), 32'(e.addr));
      chk("wr_data",    wb_if.Wr_Data,          e.data);
    end
  end

  task automatic chk_out_zero(input string tag);
    chk({tag, "_rw"},   32'(wb_if.Reg_Write),  32'd0);
    chk({tag, "_addr"}, 32'(wb_if.Wr_Address), 32'd0);
    chk({tag, "_data"}, wb_if.Wr_Data,          32'd0);
    chk({tag, "_src"},  32'(wb_if.Grant_Src),  32'd0);
  endtask

  initial begin
    int nld;
    logic alu_done;

    Rst_n           = 1'b0;
    wb_if.Ld_Valid  = 1'b0; wb_if.Ld_Rd  = '0; wb_if.Ld_Data  = '0;
    wb_if.Md_Valid  = 1'b0; wb_if.Md_Rd  = '0; wb_if.Md_Data  = '0;
    wb_if.Alu_Valid = 1'b0; wb_if.Alu_Rd = '0; wb_if.Alu_Data = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk_out_zero("reset");
    chk("reset_readys", 32'({wb_if.Ld_Ready, wb_if.Md_Ready, wb_if.Alu_Ready}), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Single ALU source, then an idle cycle that must hold address/data
    @(negedge Clk);
    wb_if.Alu_Valid = 1'b1; wb_if.Alu_Rd = 5'd3; wb_if.Alu_Data = 32'h1234_5678;
    expect_cycle(2'd3);
    @(negedge Clk);
    wb_if.Alu_Valid = 1'b0;
    expect_cycle(2'd0);

    // x0 destination is consumed without a write
    @(negedge Clk);
    wb_if.Md_Valid = 1'b1; wb_if.Md_Rd = 5'd0; wb_if.Md_Data = 32'hFFFF_FFFF;
    expect_cycle(2'd2);
    @(negedge Clk);
    wb_if.Md_Valid = 1'b0;
    expect_cycle(2'd0);

    // Base priority with all three valid
    @(negedge Clk);
    wb_if.Ld_Valid  = 1'b1; wb_if.Ld_Rd  = 5'd1; wb_if.Ld_Data  = 32'hA000_0001;
    wb_if.Md_Valid  = 1'b1; wb_if.Md_Rd  = 5'd2; wb_if.Md_Data  = 32'hA000_0002;
    wb_if.Alu_Valid = 1'b1; wb_if.Alu_Rd = 5'd3; wb_if.Alu_Data = 32'hA000_0003;
    expect_cycle(2'd1);
    @(negedge Clk);
    wb_if.Ld_Valid = 1'b0;
    expect_cycle(2'd2);
    @(negedge Clk);
    wb_if.Md_Valid = 1'b0;
    expect_cycle(2'd3);
    @(negedge Clk);
    wb_if.Alu_Valid = 1'b0;
    expect_cycle(2'd0);

    // Reset mid-transfer: output has a live write, pending x5 must be dropped
    @(negedge Clk);
    wb_if.Alu_Valid = 1'b1; wb_if.Alu_Rd = 5'd9; wb_if.Alu_Data = 32'h0BAD_F00D;
    expect_cycle(2'd3);
    @(negedge Clk);
    wb_if.Alu_Rd = 5'd5; wb_if.Alu_Data = 32'hDEAD_BEEF;
    #2;
    Rst_n = 1'b0;
    #1;
    chk_out_zero("rst_async");
    @(posedge Clk);
    #1;
    chk_out_zero("rst_hold");
    @(negedge Clk);
    wb_if.Alu_Valid = 1'b0;
    Rst_n = 1'b1;
    sb.delete();
    exp_addr = '0;
    exp_data = '0;
    expect_cycle(2'd0);
    @(negedge Clk);
    expect_cycle(2'd0);

    // Ld streams while Alu waits with Rd=7
    nld = 0;
    alu_done = 1'b0;
`ifdef WB_STARVE_GUARD_EN
    for (int i = 0; i < 6; i++) begin
`else
    for (int i = 0; i < 50; i++) begin
`endif
      @(negedge Clk);
      if (alu_done) wb_if.Alu_Valid = 1'b0;
      else begin
        wb_if.Alu_Valid = 1'b1; wb_if.Alu_Rd = 5'd7; wb_if.Alu_Data = 32'h7777_0007;
      end
      wb_if.Ld_Valid = 1'b1;
      wb_if.Ld_Rd    = 5'(10 + nld);
      wb_if.Ld_Data  = 32'h1000_0000 + 32'(nld);
`ifdef WB_STARVE_GUARD_EN
      if (i == 4) begin
        expect_cycle(2'd3);
        alu_done = 1'b1;
      end else begin
        expect_cycle(2'd1);
        nld++;
      end
`else
      expect_cycle(2'd1);
      nld++;
`endif
    end
    @(negedge Clk);
    wb_if.Ld_Valid = 1'b0;
    expect_cycle(alu_done ? 2'd0 : 2'd3);
    @(negedge Clk);
    wb_if.Alu_Valid = 1'b0;
    expect_cycle(2'd0);

    repeat (2) @(posedge Clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
